control_register_file: RTL and testbench

Parametrised per-core control register file for the GPGPU core. It holds per-strand system state: fault PC/cause, ASID, TLB staging index and scratch registers. It also holds core-wide state: strand enables, exception handler address and a 64-bit cycle counter. It serves control-register reads and writes from the memory access stage, latches faults from writeback, and drives TLB update strobes. The read result is registered, so it arrives one cycle after the request.

---
 rtl/control_register_file_pkg.sv | 36 +++
 rtl/strand_fault_tracker.sv | 64 ++++++
 rtl/control_register_file.sv | 171 +++++++++++++++++
 tb/tb_control_register_file.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_register_file_pkg.sv
// rtl/control_register_file_pkg.sv - control register indices, strand fault states and FAULT_CAUSE layout
package control_register_file_pkg;

   typedef enum logic [4:0] {
      CR_STRAND_ID         = 5'd0,
      CR_EXCEPTION_HANDLER = 5'd1,
      CR_FAULT_ADDRESS     = 5'd2,
      CR_FAULT_CAUSE       = 5'd3,
      CR_UPDATE_TLB_INDEX  = 5'd4,
      CR_UPDATE_TLB_VA     = 5'd5,
      CR_UPDATE_TLB_PA     = 5'd6,
      CR_HALT_STRAND       = 5'd7,
      CR_STRAND_ENABLE     = 5'd8,
      CR_HALT              = 5'd9,
      CR_CURRENT_ASID      = 5'd10,
      CR_CYCLE_LO          = 5'd11,
      CR_CYCLE_HI          = 5'd12,
      CR_SCRATCH0          = 5'd13,
      CR_SCRATCH1          = 5'd14,
      CR_EXCEPTION_ACK     = 5'd15
   } control_register_t;

   typedef enum logic {
      SS_IDLE       = 1'b0,
      SS_IN_HANDLER = 1'b1
   } strand_state_t;

   // FAULT_CAUSE word: {double_fault, in_handler, cause[cause_bits-1:0]}, zero-extended.
   function automatic logic [31:0] fault_cause_word(input logic        double_fault,
                                                    input logic        in_handler,
                                                    input logic [31:0] cause,
                                                    input int          cause_bits);
      return cause | (32'(in_handler) << cause_bits) | (32'(double_fault) << (cause_bits + 1));
   endfunction

endpackage

// File: rtl/strand_fault_tracker.sv
// rtl/strand_fault_tracker.sv - one strand's fault FSM with saved pc, cause and sticky double-fault flag
module strand_fault_tracker
   import control_register_file_pkg::*;
#(
   parameter int CAUSE_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fault_en,
   input  logic [31:0]           fault_pc,
   input  logic [CAUSE_BITS-1:0] fault_cause,
   input  logic                  ack_en,
   output logic                  in_handler,
   output logic                  double_fault,
   output logic [31:0]           saved_pc,
   output logic [CAUSE_BITS-1:0] saved_cause
);

   strand_state_t         state_q, state_d;
   logic                  double_fault_q, double_fault_d;
   logic [31:0]           saved_pc_q, saved_pc_d;
   logic [CAUSE_BITS-1:0] saved_cause_q, saved_cause_d;

   // The acknowledge is resolved before the fault so a same-cycle pair re-enters the handler cleanly.
   always_comb begin
      state_d        = state_q;
      double_fault_d = double_fault_q;
      saved_pc_d     = saved_pc_q;
      saved_cause_d  = saved_cause_q;
      if (ack_en) begin
         state_d        = SS_IDLE;
         double_fault_d = 1'b0;
      end
      if (fault_en) begin
         if (state_d == SS_IDLE) begin
            state_d       = SS_IN_HANDLER;
            saved_pc_d    = fault_pc;
            saved_cause_d = fault_cause;
         end else begin
            double_fault_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= SS_IDLE;
         double_fault_q <= 1'b0;
         saved_pc_q     <= '0;
         saved_cause_q  <= '0;
      end else begin
         state_q        <= state_d;
         double_fault_q <= double_fault_d;
         saved_pc_q     <= saved_pc_d;
         saved_cause_q  <= saved_cause_d;
      end
   end

   assign in_handler   = (state_q == SS_IN_HANDLER);
   assign double_fault = double_fault_q;
   assign saved_pc     = saved_pc_q;
   assign saved_cause  = saved_cause_q;

endmodule

// File: rtl/control_register_file.sv
// rtl/control_register_file.sv - per-core control registers: strand state, TLB update strobes, cycle counter
module control_register_file
   import control_register_file_pkg::*;
#(
   parameter int          CORE_ID           = 0,
   parameter int          NUM_STRANDS       = 4,
   parameter int          ASID_BITS         = 8,
   parameter int          TLB_INDEX_BITS    = 6,
   parameter int          CAUSE_BITS        = 4,
   parameter logic [63:0] CYCLE_RESET_VALUE = 64'd0,
   localparam int         SW                = (NUM_STRANDS > 1) ? $clog2(NUM_STRANDS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ma_cr_read_en,
   input  logic                      ma_cr_write_en,
   input  logic [4:0]                ma_cr_index,
   input  logic [SW-1:0]             ma_strand,
   input  logic [31:0]               ma_cr_write_value,
   input  logic                      wb_latch_fault,
   input  logic [SW-1:0]             wb_fault_strand,
   input  logic [31:0]               wb_fault_pc,
   input  logic [CAUSE_BITS-1:0]     wb_fault_cause,
   output logic [31:0]               cr_read_value,
   output logic                      cr_read_valid,
   output logic [NUM_STRANDS-1:0]    cr_strand_enable,
   output logic [31:0]               cr_exception_handler_address,
   output logic [ASID_BITS-1:0]      cr_current_asid [NUM_STRANDS],
   output logic                      cr_update_itlb_va_en,
   output logic                      cr_update_itlb_pa_en,
   output logic                      cr_update_dtlb_va_en,
   output logic                      cr_update_dtlb_pa_en,
   output logic [TLB_INDEX_BITS-1:0] cr_update_tlb_index,
   output logic [31:0]               cr_update_tlb_value,
   output logic [NUM_STRANDS-1:0]    cr_double_fault
);

   logic [NUM_STRANDS-1:0] enable_q, enable_d;
   logic [31:0]            handler_q, handler_d;
   logic [ASID_BITS-1:0]   asid_q [NUM_STRANDS];
   logic [ASID_BITS-1:0]   asid_d [NUM_STRANDS];
   logic [TLB_INDEX_BITS:0] tlb_idx_q [NUM_STRANDS];
   logic [TLB_INDEX_BITS:0] tlb_idx_d [NUM_STRANDS];
   logic [31:0]            scratch0_q [NUM_STRANDS];
   logic [31:0]            scratch0_d [NUM_STRANDS];
   logic [31:0]            scratch1_q [NUM_STRANDS];
   logic [31:0]            scratch1_d [NUM_STRANDS];
   logic [63:0]            cycle_q, cycle_d;
   logic [31:0]            cycle_hi_q, cycle_hi_d;
   logic [31:0]            read_value_q, read_value_d;
   logic                   read_valid_q, read_valid_d;
   logic [31:0]            rd_data;

   logic [NUM_STRANDS-1:0] fault_hit, ack_hit, in_handler, double_fault;
   logic [31:0]            saved_pc [NUM_STRANDS];
   logic [CAUSE_BITS-1:0]  saved_cause [NUM_STRANDS];

   for (genvar i = 0; i < NUM_STRANDS; i++) begin : g_strand
      assign fault_hit[i] = wb_latch_fault && (wb_fault_strand == SW'(i));
      assign ack_hit[i]   = ma_cr_write_en && (ma_cr_index == CR_EXCEPTION_ACK) && (ma_strand == SW'(i));

      strand_fault_tracker #(.CAUSE_BITS(CAUSE_BITS)) u_tracker (
         .clk          (clk),
         .reset        (reset),
         .fault_en     (fault_hit[i]),
         .fault_pc     (wb_fault_pc),
         .fault_cause  (wb_fault_cause),
         .ack_en       (ack_hit[i]),
         .in_handler   (in_handler[i]),
         .double_fault (double_fault[i]),
         .saved_pc     (saved_pc[i]),
         .saved_cause  (saved_cause[i])
      );
   end

   always_comb begin
      rd_data = '0;
      case (ma_cr_index)
         CR_STRAND_ID:         rd_data = (32'(CORE_ID) << SW) | 32'(ma_strand);
         CR_EXCEPTION_HANDLER: rd_data = handler_q;
         CR_FAULT_ADDRESS:     rd_data = saved_pc[ma_strand];
         CR_FAULT_CAUSE:       rd_data = fault_cause_word(double_fault[ma_strand], in_handler[ma_strand],
                                                          32'(saved_cause[ma_strand]), CAUSE_BITS);
         CR_UPDATE_TLB_INDEX:  rd_data = 32'(tlb_idx_q[ma_strand]);
         CR_STRAND_ENABLE:     rd_data = 32'(enable_q);
         CR_CURRENT_ASID:      rd_data = 32'(asid_q[ma_strand]);
         CR_CYCLE_LO:          rd_data = cycle_q[31:0];
         CR_CYCLE_HI:          rd_data = cycle_hi_q;
         CR_SCRATCH0:          rd_data = scratch0_q[ma_strand];
         CR_SCRATCH1:          rd_data = scratch1_q[ma_strand];
         default:              rd_data = '0;
      endcase
   end

   always_comb begin
      enable_d     = enable_q;
      handler_d    = handler_q;
      asid_d       = asid_q;
      tlb_idx_d    = tlb_idx_q;
      scratch0_d   = scratch0_q;
      scratch1_d   = scratch1_q;
      cycle_d      = cycle_q + 64'd1;
      cycle_hi_d   = cycle_hi_q;
      read_valid_d = ma_cr_read_en;
      read_value_d = read_value_q;
      // Snapshot the high half alongside the low-half read so LO-then-HI is coherent.
      if (ma_cr_read_en) begin
         read_value_d = rd_data;
         if (ma_cr_index == CR_CYCLE_LO) cycle_hi_d = cycle_q[63:32];
      end
      if (ma_cr_write_en) begin
         case (ma_cr_index)
            CR_EXCEPTION_HANDLER: handler_d             = ma_cr_write_value;
            CR_UPDATE_TLB_INDEX:  tlb_idx_d[ma_strand]  = ma_cr_write_value[TLB_INDEX_BITS:0];
            CR_HALT_STRAND:       enable_d[ma_strand]   = 1'b0;
            CR_STRAND_ENABLE:     enable_d              = ma_cr_write_value[NUM_STRANDS-1:0];
            CR_HALT:              enable_d              = '0;
            CR_CURRENT_ASID:      asid_d[ma_strand]     = ma_cr_write_value[ASID_BITS-1:0];
            CR_SCRATCH0:          scratch0_d[ma_strand] = ma_cr_write_value;
            CR_SCRATCH1:          scratch1_d[ma_strand] = ma_cr_write_value;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable_q     <= NUM_STRANDS'(1);
         handler_q    <= '0;
         asid_q       <= '{default: '0};
         tlb_idx_q    <= '{default: '0};
         scratch0_q   <= '{default: '0};
         scratch1_q   <= '{default: '0};
         cycle_q      <= CYCLE_RESET_VALUE;
         cycle_hi_q   <= '0;
         read_value_q <= '0;
         read_valid_q <= 1'b0;
      end else begin
         enable_q     <= enable_d;
         handler_q    <= handler_d;
         asid_q       <= asid_d;
         tlb_idx_q    <= tlb_idx_d;
         scratch0_q   <= scratch0_d;
         scratch1_q   <= scratch1_d;
         cycle_q      <= cycle_d;
         cycle_hi_q   <= cycle_hi_d;
         read_value_q <= read_value_d;
         read_valid_q <= read_valid_d;
      end
   end

   logic tlb_va_wr, tlb_pa_wr, itlb_sel;
   assign tlb_va_wr = ma_cr_write_en && (ma_cr_index == CR_UPDATE_TLB_VA);
   assign tlb_pa_wr = ma_cr_write_en && (ma_cr_index == CR_UPDATE_TLB_PA);
   assign itlb_sel  = tlb_idx_q[ma_strand][TLB_INDEX_BITS];

   assign cr_update_itlb_va_en = tlb_va_wr && itlb_sel;
   assign cr_update_dtlb_va_en = tlb_va_wr && !itlb_sel;
   assign cr_update_itlb_pa_en = tlb_pa_wr && itlb_sel;
   assign cr_update_dtlb_pa_en = tlb_pa_wr && !itlb_sel;
   assign cr_update_tlb_index  = tlb_idx_q[ma_strand][TLB_INDEX_BITS-1:0];
   assign cr_update_tlb_value  = ma_cr_write_value;

   assign cr_read_value                = read_value_q;
   assign cr_read_valid                = read_valid_q;
   assign cr_strand_enable             = enable_q;
   assign cr_exception_handler_address = handler_q;
   assign cr_current_asid              = asid_q;
   assign cr_double_fault              = double_fault;

endmodule

// File: tb/tb_control_register_file.sv
// tb/tb_control_register_file.sv - directed self-checking bench for control_register_file
module tb_control_register_file;

   localparam int          NS    = 4;
   localparam int          SW    = 2;
   localparam int          AB    = 8;
   localparam int          TB    = 6;
   localparam int          CB    = 4;
   localparam int          CORE  = 3;
   localparam logic [63:0] CINIT = 64'h0000_0001_FFFF_FFC0;

   logic          clk;
   logic          rst_n;
   logic          read_en, write_en;
   logic [4:0]    index;
   logic [SW-1:0] strand;
   logic [31:0]   wvalue;
   logic          latch_fault;
   logic [SW-1:0] fault_strand;
   logic [31:0]   fault_pc;
   logic [CB-1:0] fault_cause;
   logic [31:0]   read_value;
   logic          read_valid;
   logic [NS-1:0] strand_enable;
   logic [31:0]   handler_addr;
   logic [AB-1:0] asid [NS];
   logic          itlb_va, itlb_pa, dtlb_va, dtlb_pa;
   logic [TB-1:0] tlb_index;
   logic [31:0]   tlb_value;
   logic [NS-1:0] dbl_fault;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] cyc;
   int          zero_idx [10] = '{12, 1, 2, 3, 4, 10, 13, 14, 7, 20};

   control_register_file #(
      .CORE_ID(CORE), .NUM_STRANDS(NS), .ASID_BITS(AB), .TLB_INDEX_BITS(TB),
      .CAUSE_BITS(CB), .CYCLE_RESET_VALUE(CINIT)
   ) dut (
      .clk                          (clk),
      .reset                        (rst_n),
      .ma_cr_read_en                (read_en),
      .ma_cr_write_en               (write_en),
      .ma_cr_index                  (index),
      .ma_strand                    (strand),
      .ma_cr_write_value            (wvalue),
      .wb_latch_fault               (latch_fault),
      .wb_fault_strand              (fault_strand),
      .wb_fault_pc                  (fault_pc),
      .wb_fault_cause               (fault_cause),
      .cr_read_value                (read_value),
      .cr_read_valid                (read_valid),
      .cr_strand_enable             (strand_enable),
      .cr_exception_handler_address (handler_addr),
      .cr_current_asid              (asid),
      .cr_update_itlb_va_en         (itlb_va),
      .cr_update_itlb_pa_en         (itlb_pa),
      .cr_update_dtlb_va_en         (dtlb_va),
      .cr_update_dtlb_pa_en         (dtlb_pa),
      .cr_update_tlb_index          (tlb_index),
      .cr_update_tlb_value          (tlb_value),
      .cr_double_fault              (dbl_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 64'd0;
      else        cyc <= cyc + 64'd1;
   end

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cr_read(input logic [4:0] idx, input logic [SW-1:0] s,
                          output logic [31:0] val, output logic [63:0] at_cyc);
      @(negedge clk);
      read_en = 1'b1; index = idx; strand = s;
      at_cyc = cyc;
      @(negedge clk);
      val = read_value;
      check_value("read_valid", 64'(read_valid), 64'd1);
      read_en = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [4:0] idx, input logic [SW-1:0] s,
                             input logic [31:0] exp);
      logic [31:0] v;
      logic [63:0] c;
      cr_read(idx, s, v, c);
      check_value(tag, 64'(v), 64'(exp));
   endtask

   task automatic cr_write(input logic [4:0] idx, input logic [SW-1:0] s, input logic [31:0] val);
      @(negedge clk);
      write_en = 1'b1; index = idx; strand = s; wvalue = val;
      @(negedge clk);
      write_en = 1'b0;
   endtask

   task automatic fault(input logic [SW-1:0] s, input logic [31:0] pc, input logic [CB-1:0] cause);
      @(negedge clk);
      latch_fault = 1'b1; fault_strand = s; fault_pc = pc; fault_cause = cause;
      @(negedge clk);
      latch_fault = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [63:0] c;
      logic [63:0] exp64;

      rst_n = 1'b0; read_en = 1'b0; write_en = 1'b0; index = '0; strand = '0; wvalue = '0;
      latch_fault = 1'b0; fault_strand = '0; fault_pc = '0; fault_cause = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_value("rst_enable", 64'(strand_enable), 64'h1);
      check_value("rst_handler", 64'(handler_addr), 64'h0);
      check_value("rst_dbl", 64'(dbl_fault), 64'h0);
      check_value("rst_rvalid", 64'(read_valid), 64'h0);
      check_value("rst_rvalue", 64'(read_value), 64'h0);
      check_value("rst_asid3", 64'(asid[3]), 64'h0);
      check_value("rst_strobes", 64'({itlb_va, itlb_pa, dtlb_va, dtlb_pa}), 64'h0);

      foreach (zero_idx[i]) read_check("rst_read_zero", 5'(zero_idx[i]), 2'd0, 32'h0);
      @(negedge clk);
      check_value("rvalid_drop", 64'(read_valid), 64'h0);
      read_check("rst_read_enable", 5'd8, 2'd0, 32'h1);
      read_check("strand_id", 5'd0, 2'd2, 32'hE);

      // Counter: LO read shortly before the low half wraps, HI read after it wrapped.
      while (cyc < 64'd59) @(negedge clk);
      cr_read(5'd11, 2'd0, v, c);
      exp64 = CINIT + c;
      check_value("cycle_lo", 64'(v), 64'(exp64[31:0]));
      repeat (5) @(negedge clk);
      read_check("cycle_hi_snapshot", 5'd12, 2'd0, 32'h1);
      cr_read(5'd11, 2'd0, v, c);
      exp64 = CINIT + c;
      check_value("cycle_lo_wrapped", 64'(v), 64'(exp64[31:0]));
      read_check("cycle_hi_after_wrap", 5'd12, 2'd0, 32'h2);

      cr_write(5'd8, 2'd0, 32'hFFFF_FFFF);
      read_check("enable_write", 5'd8, 2'd0, 32'hF);
      check_value("enable_out", 64'(strand_enable), 64'hF);

      cr_write(5'd2, 2'd0, 32'hDEAD);
      read_check("ro_fault_addr", 5'd2, 2'd0, 32'h0);
      cr_write(5'd10, 2'd1, 32'h1AB);
      read_check("asid_trunc", 5'd10, 2'd1, 32'hAB);
      check_value("asid_out", 64'(asid[1]), 64'hAB);
      cr_write(5'd13, 2'd3, 32'h1234_5678);
      read_check("scratch0_s3", 5'd13, 2'd3, 32'h1234_5678);
      read_check("scratch0_s0", 5'd13, 2'd0, 32'h0);
      cr_write(5'd1, 2'd0, 32'h0000_8000);
      check_value("handler_out", 64'(handler_addr), 64'h8000);

      cr_write(5'd4, 2'd2, 32'h45);
      read_check("tlb_index_s2", 5'd4, 2'd2, 32'h45);
      @(negedge clk);
      write_en = 1'b1; index = 5'd5; strand = 2'd2; wvalue = 32'h1000;
      #1;
      check_value("itlb_va_strobes", 64'({itlb_va, itlb_pa, dtlb_va, dtlb_pa}), 64'b1000);
      check_value("itlb_va_index", 64'(tlb_index), 64'h05);
      check_value("itlb_va_value", 64'(tlb_value), 64'h1000);
      @(negedge clk);
      write_en = 1'b0;
      #1;
      check_value("itlb_va_release", 64'({itlb_va, itlb_pa, dtlb_va, dtlb_pa}), 64'b0000);

      cr_write(5'd4, 2'd1, 32'h0A3);
      @(negedge clk);
      write_en = 1'b1; index = 5'd6; strand = 2'd1; wvalue = 32'h2000;
      #1;
      check_value("dtlb_pa_strobes", 64'({itlb_va, itlb_pa, dtlb_va, dtlb_pa}), 64'b0001);
      check_value("dtlb_pa_index", 64'(tlb_index), 64'h23);
      @(negedge clk);
      write_en = 1'b0;

      fault(2'd1, 32'h200, 4'd3);
      fault(2'd1, 32'h300, 4'd5);
      read_check("fault_pc_s1", 5'd2, 2'd1, 32'h200);
      read_check("fault_cause_dbl", 5'd3, 2'd1, 32'h33);
      check_value("dbl_out_s1", 64'(dbl_fault), 64'b0010);
      cr_write(5'd15, 2'd1, 32'h0);
      read_check("fault_cause_acked", 5'd3, 2'd1, 32'h03);
      check_value("dbl_out_cleared", 64'(dbl_fault), 64'b0000);

      fault(2'd0, 32'h400, 4'd1);
      @(negedge clk);
      write_en = 1'b1; index = 5'd15; strand = 2'd0; wvalue = '0;
      latch_fault = 1'b1; fault_strand = 2'd0; fault_pc = 32'h500; fault_cause = 4'd2;
      @(negedge clk);
      write_en = 1'b0; latch_fault = 1'b0;
      read_check("ack_fault_pc", 5'd2, 2'd0, 32'h500);
      read_check("ack_fault_cause", 5'd3, 2'd0, 32'h12);
      check_value("ack_fault_dbl", 64'(dbl_fault), 64'b0000);

      @(negedge clk);
      latch_fault = 1'b1; fault_strand = 2'd2; fault_pc = 32'h600; fault_cause = 4'd4;
      @(negedge clk);
      fault_strand = 2'd3; fault_pc = 32'h700; fault_cause = 4'd6;
      @(negedge clk);
      latch_fault = 1'b0;
      read_check("indep_pc_s2", 5'd2, 2'd2, 32'h600);
      read_check("indep_pc_s3", 5'd2, 2'd3, 32'h700);
      read_check("indep_cause_s3", 5'd3, 2'd3, 32'h16);
      fault(2'd3, 32'h800, 4'd7);
      check_value("dbl_out_s3", 64'(dbl_fault), 64'b1000);

      cr_write(5'd7, 2'd2, 32'h0);
      check_value("halt_strand", 64'(strand_enable), 64'hB);
      cr_write(5'd9, 2'd0, 32'h0);
      check_value("halt_all", 64'(strand_enable), 64'h0);

      cr_write(5'd8, 2'd0, 32'hF);
      @(negedge clk);
      write_en = 1'b1; index = 5'd9; strand = 2'd0; wvalue = '0;
      #2;
      rst_n = 1'b0;
      #1;
      check_value("midrst_enable", 64'(strand_enable), 64'h1);
      check_value("midrst_handler", 64'(handler_addr), 64'h0);
      check_value("midrst_dbl", 64'(dbl_fault), 64'h0);
      check_value("midrst_asid1", 64'(asid[1]), 64'h0);
      @(negedge clk);
      write_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_value("postrst_enable", 64'(strand_enable), 64'h1);
      read_check("postrst_hi", 5'd12, 2'd0, 32'h0);
      read_check("postrst_pc_s3", 5'd2, 2'd3, 32'h0);
      read_check("postrst_scratch", 5'd13, 2'd3, 32'h0);
      read_check("postrst_tlb_idx", 5'd4, 2'd2, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
